// File: rtl/axi_req_arbiter_if.sv
// Requester and shared-master signal bundle for axi_req_arbiter.
// The arbiter connects through the slave modport; the requesters/master model use the master modport.
interface axi_req_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 128
);
    logic              s0_valid;
    logic              s0_ready;
    logic              s0_rw;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_wdata;
    logic              s0_done;
    logic [DATA_W-1:0] s0_rdata;
    logic              s0_err;

    logic              s1_valid;
    logic              s1_ready;
    logic              s1_rw;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_wdata;
    logic              s1_done;
    logic [DATA_W-1:0] s1_rdata;
    logic              s1_err;

    logic              m_valid;
    logic              m_ready;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_done;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;

    logic              busy;

    modport slave (
        input  s0_valid, s0_rw, s0_addr, s0_wdata,
        output s0_ready, s0_done, s0_rdata, s0_err,
        input  s1_valid, s1_rw, s1_addr, s1_wdata,
        output s1_ready, s1_done, s1_rdata, s1_err,
        output m_valid, m_rw, m_addr, m_wdata,
        input  m_ready, m_done, m_rdata, m_err,
        output busy
    );

    modport master (
        output s0_valid, s0_rw, s0_addr, s0_wdata,
        input  s0_ready, s0_done, s0_rdata, s0_err,
        output s1_valid, s1_rw, s1_addr, s1_wdata,
        input  s1_ready, s1_done, s1_rdata, s1_err,
        input  m_valid, m_rw, m_addr, m_wdata,
        output m_ready, m_done, m_rdata, m_err,
        input  busy
    );
endinterface

// File: rtl/axi_req_arbiter.sv
// Two-requester round-robin arbiter onto one AXI master user port, one command in flight.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT).
module axi_req_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    axi_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_s0_rdata;
    logic [DATA_W-1:0] r_s1_rdata;
    logic              r_s0_err;
    logic              r_s1_err;

    logic              w_pick;
    logic              w_accept;
    logic              w_timeout;
    logic              w_finish;
    logic              w_fin_err;
    logic              w_fin_read;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd;

    always_ff @(posedge clk) begin
        if (!reset)
            r_wd <= '0;
        else if (w_accept)
            r_wd <= '0;
        else if (r_state == ISSUE || r_state == WAIT)
            r_wd <= r_wd + 1'b1;
    end

    // Fires on the cycle whose increment would reach TIMEOUT, so RESP lands TIMEOUT cycles after ISSUE entry.
    assign w_timeout = (r_state == ISSUE || r_state == WAIT) && (r_wd == WD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Accept is combinational in IDLE and gated by reset so nothing is granted while reset is held.
    always_comb begin
        w_pick   = (bus.s0_valid && bus.s1_valid) ? ~r_last_grant : bus.s1_valid;
        w_accept = reset && (r_state == IDLE) && (bus.s0_valid || bus.s1_valid);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_read  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_timeout) begin
                    w_state_nxt = RESP;
                    w_finish    = 1'b1;
                    w_fin_err   = 1'b1;
                end else if (bus.m_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.m_done) begin
                    w_state_nxt = RESP;
                    w_finish    = 1'b1;
                    w_fin_err   = bus.m_err;
                    w_fin_read  = ~r_rw;
                end else if (w_timeout) begin
                    w_state_nxt = RESP;
                    w_finish    = 1'b1;
                    w_fin_err   = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_s0_rdata   <= '0;
            r_s1_rdata   <= '0;
            r_s0_err     <= 1'b0;
            r_s1_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_pick;
                r_rw    <= w_pick ? bus.s1_rw    : bus.s0_rw;
                r_addr  <= w_pick ? bus.s1_addr  : bus.s0_addr;
                r_wdata <= w_pick ? bus.s1_wdata : bus.s0_wdata;
            end
            // Completion status lands on entry to RESP so it is visible alongside the done pulse.
            if (w_finish) begin
                if (r_grant) begin
                    r_s1_err <= w_fin_err;
                    if (w_fin_read)
                        r_s1_rdata <= bus.m_rdata;
                end else begin
                    r_s0_err <= w_fin_err;
                    if (w_fin_read)
                        r_s0_rdata <= bus.m_rdata;
                end
            end
            if (r_state == RESP)
                r_last_grant <= r_grant;
        end
    end

    assign bus.s0_ready = w_accept && !w_pick;
    assign bus.s1_ready = w_accept &&  w_pick;
    assign bus.s0_done  = (r_state == RESP) && !r_grant;
    assign bus.s1_done  = (r_state == RESP) &&  r_grant;
    assign bus.s0_rdata = r_s0_rdata;
    assign bus.s1_rdata = r_s1_rdata;
    assign bus.s0_err   = r_s0_err;
    assign bus.s1_err   = r_s1_err;
    assign bus.m_valid  = (r_state == ISSUE);
    assign bus.m_rw     = r_rw;
    assign bus.m_addr   = r_addr;
    assign bus.m_wdata  = r_wdata;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_axi_req_arbiter.sv
// Randomized self-checking bench for axi_req_arbiter against a transaction-level model.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_axi_req_arbiter;
    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 128;
    localparam int unsigned TO   = 8;
    localparam int unsigned ALLW = 2 * (DW + 3) + AW + DW + 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Transaction-level model: who was served last, and what each requester was last told.
    bit          mdl_last;
    logic [DW-1:0] mdl_rdata [2];
    bit          mdl_err [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [5:0] ctrl();
        return {bus.s0_ready, bus.s1_ready, bus.s0_done, bus.s1_done, bus.m_valid, bus.busy};
    endfunction

    function automatic logic [ALLW-1:0] allout();
        return {bus.s0_ready, bus.s0_done, bus.s0_err, bus.s0_rdata,
                bus.s1_ready, bus.s1_done, bus.s1_err, bus.s1_rdata,
                bus.m_valid, bus.m_rw, bus.busy, bus.m_addr, bus.m_wdata};
    endfunction

    function automatic logic [AW-1:0] rnd_a();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] rnd_d();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        mdl_last     = 1'b1;
        mdl_err[0]   = 1'b0;
        mdl_err[1]   = 1'b0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
    endtask

    task automatic drive_idle();
        bus.s0_valid = 1'b0; bus.s0_rw = 1'b0; bus.s0_addr = '0; bus.s0_wdata = '0;
        bus.s1_valid = 1'b0; bus.s1_rw = 1'b0; bus.s1_addr = '0; bus.s1_wdata = '0;
        bus.m_ready  = 1'b0; bus.m_done = 1'b0; bus.m_rdata = '0; bus.m_err = 1'b0;
    endtask

    // Runs one arbitration + command + completion, starting in an IDLE cycle and ending in the next IDLE cycle.
    task automatic do_txn(input string name, input bit v0, input bit v1, input bit rw0, input bit rw1,
                          input bit drop, input int unsigned rdly, input int unsigned ddly, input bit merr,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] rd);
        bit w;
        logic [AW+DW:0] exp_cmd;
        logic [5:0] exp_ctrl;
        w = (v0 && v1) ? ~mdl_last : v1;
        exp_cmd = w ? {rw1, a1, d1} : {rw0, a0, d0};

        bus.s0_valid = v0; bus.s0_rw = rw0; bus.s0_addr = a0; bus.s0_wdata = d0;
        bus.s1_valid = v1; bus.s1_rw = rw1; bus.s1_addr = a1; bus.s1_wdata = d1;
        bus.m_ready = 1'b0; bus.m_done = 1'b1; bus.m_rdata = rnd_d(); bus.m_err = 1'b1;
        settle();
        exp_ctrl = {~w, w, 4'b0000};
        n_checks++;
        if (ctrl() !== exp_ctrl) begin
            n_fail++;
            $display("FAIL %s accept: ctrl got %b exp %b", name, ctrl(), exp_ctrl);
        end

        tick();
        if (drop) begin
            if (w) bus.s1_valid = 1'b0; else bus.s0_valid = 1'b0;
        end
        bus.s0_rw = ~rw0; bus.s0_addr = rnd_a(); bus.s0_wdata = rnd_d();
        bus.s1_rw = ~rw1; bus.s1_addr = rnd_a(); bus.s1_wdata = rnd_d();
        for (int unsigned i = 0; i <= rdly; i++) begin
            bus.m_ready = (i == rdly);
            bus.m_done  = 1'($urandom_range(0, 1));
            settle();
            n_checks++;
            if (ctrl() !== 6'b000011) begin
                n_fail++;
                $display("FAIL %s issue%0d: ctrl got %b exp 000011", name, i, ctrl());
            end
            n_checks++;
            if ({bus.m_rw, bus.m_addr, bus.m_wdata} !== exp_cmd) begin
                n_fail++;
                $display("FAIL %s cmd%0d: got %h exp %h", name, i, {bus.m_rw, bus.m_addr, bus.m_wdata}, exp_cmd);
            end
            tick();
        end

        bus.m_ready = 1'b0;
        for (int unsigned i = 0; i <= ddly; i++) begin
            bus.m_done  = (i == ddly);
            bus.m_rdata = (i == ddly) ? rd : rnd_d();
            bus.m_err   = (i == ddly) ? merr : 1'($urandom_range(0, 1));
            settle();
            n_checks++;
            if (ctrl() !== 6'b000001) begin
                n_fail++;
                $display("FAIL %s wait%0d: ctrl got %b exp 000001", name, i, ctrl());
            end
            tick();
        end

        mdl_err[w] = merr;
        if (!(w ? rw1 : rw0)) mdl_rdata[w] = rd;
        mdl_last = w;

        bus.m_done = 1'($urandom_range(0, 1)); bus.m_rdata = rnd_d(); bus.m_err = 1'b1;
        settle();
        exp_ctrl = {2'b00, ~w, w, 1'b0, 1'b1};
        n_checks++;
        if (ctrl() !== exp_ctrl) begin
            n_fail++;
            $display("FAIL %s resp: ctrl got %b exp %b", name, ctrl(), exp_ctrl);
        end
        n_checks++;
        if ({bus.s0_err, bus.s1_err} !== {mdl_err[0], mdl_err[1]}) begin
            n_fail++;
            $display("FAIL %s err: got %b exp %b", name, {bus.s0_err, bus.s1_err}, {mdl_err[0], mdl_err[1]});
        end
        n_checks++;
        if ({bus.s0_rdata, bus.s1_rdata} !== {mdl_rdata[0], mdl_rdata[1]}) begin
            n_fail++;
            $display("FAIL %s rdata: got %h/%h exp %h/%h", name, bus.s0_rdata, bus.s1_rdata, mdl_rdata[0], mdl_rdata[1]);
        end
        tick();
        bus.m_done = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.s0_valid = 1'b1; bus.s1_valid = 1'b1; bus.m_ready = 1'b1; bus.m_done = 1'b1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            n_checks++;
            if (allout() !== '0) begin
                n_fail++;
                $display("FAIL reset%0d: outputs got %h exp 0", i, allout());
            end
        end
        tick();
        drive_idle();
        reset = 1'b1;
        bus.m_done = 1'b1;
        tick();
        settle();
        n_checks++;
        if (ctrl() !== 6'b000000) begin
            n_fail++;
            $display("FAIL idle_mdone: ctrl got %b exp 000000", ctrl());
        end
        bus.m_done = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_txn("wr_s0", 1, 0, 1, 0, 0, 0, 0, 0, 64'h10, rnd_a(), 128'hAA, rnd_d(), rnd_d());
    endtask

    task automatic test_read();
        do_txn("rd_s1", 0, 1, 0, 0, 0, 0, 0, 0, rnd_a(), 64'h20, rnd_d(), rnd_d(), 128'h1234);
    endtask

    task automatic test_error();
        do_txn("err_wr_s0", 1, 0, 1, 1, 0, 1, 1, 1, rnd_a(), rnd_a(), rnd_d(), rnd_d(), rnd_d());
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++)
            do_txn($sformatf("rr%0d", i), 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   0, 0, 0, 0, rnd_a(), rnd_a(), rnd_d(), rnd_d(), rnd_d());
    endtask

    task automatic test_random();
        bit [1:0] v;
        for (int i = 0; i < 24; i++) begin
            v = 2'($urandom_range(1, 3));
            do_txn($sformatf("rnd%0d", i), v[0], v[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), rnd_a(), rnd_a(), rnd_d(), rnd_d(), rnd_d());
        end
    endtask

    // Issues an s0 read that the master accepts but never completes; returns in the first WAIT cycle.
    task automatic start_stuck_read();
        bit w;
        w = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_rw = 1'b0; bus.s0_addr = rnd_a(); bus.s0_wdata = rnd_d();
        bus.s1_valid = 1'b0;
        bus.m_ready = 1'b0; bus.m_done = 1'b0;
        settle();
        n_checks++;
        if (ctrl() !== {~w, w, 4'b0000}) begin
            n_fail++;
            $display("FAIL stuck accept: ctrl got %b exp 100000", ctrl());
        end
        tick();
        bus.s0_valid = 1'b0;
        bus.m_ready = 1'b1;
        settle();
        n_checks++;
        if (ctrl() !== 6'b000011) begin
            n_fail++;
            $display("FAIL stuck issue: ctrl got %b exp 000011", ctrl());
        end
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_timeout();
        start_stuck_read();
`ifdef ARB_TIMEOUT_EN
        for (int unsigned k = 1; k < TO; k++) begin
            settle();
            n_checks++;
            if (ctrl() !== 6'b000001) begin
                n_fail++;
                $display("FAIL timeout wait%0d: ctrl got %b exp 000001", k, ctrl());
            end
            tick();
        end
        mdl_err[0] = 1'b1;
        mdl_last = 1'b0;
        settle();
        n_checks++;
        if (ctrl() !== 6'b001001) begin
            n_fail++;
            $display("FAIL timeout resp: ctrl got %b exp 001001", ctrl());
        end
        n_checks++;
        if ({bus.s0_err, bus.s0_rdata} !== {mdl_err[0], mdl_rdata[0]}) begin
            n_fail++;
            $display("FAIL timeout status: got %h exp %h", {bus.s0_err, bus.s0_rdata}, {mdl_err[0], mdl_rdata[0]});
        end
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            settle();
            n_checks++;
            if (ctrl() !== 6'b000001) begin
                n_fail++;
                $display("FAIL no_timeout wait%0d: ctrl got %b exp 000001", k, ctrl());
            end
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
`endif
    endtask

    task automatic test_reset_mid();
        start_stuck_read();
        tick();
        reset = 1'b0;
        bus.s0_valid = 1'b1; bus.s1_valid = 1'b1; bus.m_done = 1'b1; bus.m_rdata = rnd_d();
        tick();
        settle();
        n_checks++;
        if (allout() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs got %h exp 0", allout());
        end
        model_reset();
        tick();
        reset = 1'b1;
        bus.m_done = 1'b0;
        do_txn("post_reset_tie", 1, 1, 0, 1, 0, 0, 0, 0, rnd_a(), rnd_a(), rnd_d(), rnd_d(), rnd_d());
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write();
        test_read();
        test_error();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
